// File: rtl/id_fwd_interlock_pkg.sv
// Shared definitions for the decode-stage interlock.
// Fetch bus layout and forwarding-stage indices.
package id_fwd_interlock_pkg;

  localparam int FS_TO_DS_BUS_WD = 65;

  typedef enum int {
    FWD_ES = 0,
    FWD_MS = 1,
    FWD_WS = 2
  } fwd_idx_e;

  localparam int FWD_STAGES = int'(FWD_WS) + 1;

  typedef struct packed {
    logic        ex;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

endpackage

// File: rtl/id_fwd_interlock_fwd_sel.sv
// Priority forwarding mux for one source operand.
// Lowest matching stage index is the youngest producer.
module id_fwd_interlock_fwd_sel
  import id_fwd_interlock_pkg::*;
#(
  parameter int NUM_FWD = FWD_STAGES,
  parameter int DATA_WD = 32,
  parameter int RA_WD   = 5
) (
  input  logic [RA_WD-1:0]           addr_i,
  input  logic                       used_i,
  input  logic [DATA_WD-1:0]         rf_data_i,
  input  logic [NUM_FWD-1:0]         fwd_valid_i,
  input  logic [NUM_FWD-1:0]         fwd_we_i,
  input  logic [NUM_FWD*RA_WD-1:0]   fwd_dest_i,
  input  logic [NUM_FWD*DATA_WD-1:0] fwd_data_i,
  input  logic [NUM_FWD-1:0]         fwd_ready_i,
  output logic [DATA_WD-1:0]         value_o,
  output logic                       not_ready_o
);

  logic [NUM_FWD-1:0] match;
  logic               hit;

  always_comb begin
    for (int i = 0; i < NUM_FWD; i++) begin
      match[i] = fwd_valid_i[i] & fwd_we_i[i]
               & (fwd_dest_i[i*RA_WD +: RA_WD] == addr_i)
               & (addr_i != '0);
    end
  end

  // A younger not-ready match shadows any older ready one.
  always_comb begin
    value_o     = rf_data_i;
    not_ready_o = 1'b0;
    hit         = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && match[i]) begin
        hit         = 1'b1;
        value_o     = fwd_data_i[i*DATA_WD +: DATA_WD];
        not_ready_o = used_i & ~fwd_ready_i[i];
      end
    end
  end

endmodule

// File: rtl/id_fwd_interlock.sv
// Decode-stage controller: IF/ID register, handshake,
// operand forwarding and load-use interlock.
module id_fwd_interlock
  import id_fwd_interlock_pkg::*;
#(
  parameter int BUS_WD  = FS_TO_DS_BUS_WD,
  parameter int NUM_FWD = FWD_STAGES,
  parameter int DATA_WD = 32,
  parameter int RA_WD   = 5,
  parameter int CNT_WD  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_to_ds_valid,
  input  logic [BUS_WD-1:0]          fs_to_ds_bus,
  output logic                       ds_allowin,
  input  logic                       es_allowin,
  output logic                       ds_to_es_valid,
  output logic                       ds_valid,
  output logic [BUS_WD-1:0]          ds_bus,
  input  logic [RA_WD-1:0]           rs_addr,
  input  logic [RA_WD-1:0]           rt_addr,
  input  logic                       rs_used,
  input  logic                       rt_used,
  input  logic [DATA_WD-1:0]         rf_rdata1,
  input  logic [DATA_WD-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD-1:0]         fwd_we,
  input  logic [NUM_FWD*RA_WD-1:0]   fwd_dest,
  input  logic [NUM_FWD*DATA_WD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]         fwd_ready,
  input  logic                       ex_from_ws,
  output logic [DATA_WD-1:0]         rs_value,
  output logic [DATA_WD-1:0]         rt_value,
  output logic                       hazard_stall,
  output logic [CNT_WD-1:0]          stall_cnt
);

  logic              ds_valid_q, ds_valid_d;
  logic [BUS_WD-1:0] ds_bus_q, ds_bus_d;
  logic [CNT_WD-1:0] stall_cnt_q, stall_cnt_d;
  logic              rs_not_ready;
  logic              rt_not_ready;
  logic              ds_ready_go;

  id_fwd_interlock_fwd_sel #(
    .NUM_FWD (NUM_FWD),
    .DATA_WD (DATA_WD),
    .RA_WD   (RA_WD)
  ) u_rs_sel (
    .addr_i      (rs_addr),
    .used_i      (rs_used),
    .rf_data_i   (rf_rdata1),
    .fwd_valid_i (fwd_valid),
    .fwd_we_i    (fwd_we),
    .fwd_dest_i  (fwd_dest),
    .fwd_data_i  (fwd_data),
    .fwd_ready_i (fwd_ready),
    .value_o     (rs_value),
    .not_ready_o (rs_not_ready)
  );

  id_fwd_interlock_fwd_sel #(
    .NUM_FWD (NUM_FWD),
    .DATA_WD (DATA_WD),
    .RA_WD   (RA_WD)
  ) u_rt_sel (
    .addr_i      (rt_addr),
    .used_i      (rt_used),
    .rf_data_i   (rf_rdata2),
    .fwd_valid_i (fwd_valid),
    .fwd_we_i    (fwd_we),
    .fwd_dest_i  (fwd_dest),
    .fwd_data_i  (fwd_data),
    .fwd_ready_i (fwd_ready),
    .value_o     (rt_value),
    .not_ready_o (rt_not_ready)
  );

  assign hazard_stall   = ds_valid_q & (rs_not_ready | rt_not_ready);
  assign ds_ready_go    = ~hazard_stall;
  assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid_q & ds_ready_go & ~ex_from_ws;

  // Flush beats the handshake; the payload only moves on a real accept.
  always_comb begin
    ds_valid_d  = ds_valid_q;
    ds_bus_d    = ds_bus_q;
    stall_cnt_d = stall_cnt_q;
    if (ex_from_ws) begin
      ds_valid_d = 1'b0;
    end else if (ds_allowin) begin
      ds_valid_d = fs_to_ds_valid;
    end
    if (fs_to_ds_valid && ds_allowin && !ex_from_ws) begin
      ds_bus_d = fs_to_ds_bus;
    end
    if (hazard_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q  <= 1'b0;
      ds_bus_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      ds_bus_q    <= ds_bus_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ds_valid  = ds_valid_q;
  assign ds_bus    = ds_bus_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_interlock.sv
// Directed bench for the decode interlock.
// Counter is narrowed to 4 bits to reach saturation quickly.
module tb_id_fwd_interlock;

  localparam int BUS_WD  = 65;
  localparam int NUM_FWD = 3;
  localparam int DATA_WD = 32;
  localparam int RA_WD   = 5;
  localparam int CNT_WD  = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       fs_to_ds_valid;
  logic [BUS_WD-1:0]          fs_to_ds_bus;
  logic                       ds_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic                       ds_valid;
  logic [BUS_WD-1:0]          ds_bus;
  logic [RA_WD-1:0]           rs_addr;
  logic [RA_WD-1:0]           rt_addr;
  logic                       rs_used;
  logic                       rt_used;
  logic [DATA_WD-1:0]         rf_rdata1;
  logic [DATA_WD-1:0]         rf_rdata2;
  logic [NUM_FWD-1:0]         fwd_valid;
  logic [NUM_FWD-1:0]         fwd_we;
  logic [NUM_FWD*RA_WD-1:0]   fwd_dest;
  logic [NUM_FWD*DATA_WD-1:0] fwd_data;
  logic [NUM_FWD-1:0]         fwd_ready;
  logic                       ex_from_ws;
  logic [DATA_WD-1:0]         rs_value;
  logic [DATA_WD-1:0]         rt_value;
  logic                       hazard_stall;
  logic [CNT_WD-1:0]          stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_fwd_interlock #(
    .BUS_WD  (BUS_WD),
    .NUM_FWD (NUM_FWD),
    .DATA_WD (DATA_WD),
    .RA_WD   (RA_WD),
    .CNT_WD  (CNT_WD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_valid       (ds_valid),
    .ds_bus         (ds_bus),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_used        (rs_used),
    .rt_used        (rt_used),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .fwd_valid      (fwd_valid),
    .fwd_we         (fwd_we),
    .fwd_dest       (fwd_dest),
    .fwd_data       (fwd_data),
    .fwd_ready      (fwd_ready),
    .ex_from_ws     (ex_from_ws),
    .rs_value       (rs_value),
    .rt_value       (rt_value),
    .hazard_stall   (hazard_stall),
    .stall_cnt      (stall_cnt)
  );

  task automatic check(input string tag,
                       input logic [64:0] got,
                       input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic v,
                         input logic [RA_WD-1:0] dest,
                         input logic [DATA_WD-1:0] data,
                         input logic rdy);
    fwd_valid[i] = v;
    fwd_we[i]    = v;
    fwd_dest[i*RA_WD +: RA_WD]     = dest;
    fwd_data[i*DATA_WD +: DATA_WD] = data;
    fwd_ready[i] = rdy;
  endtask

  task automatic clr_fwd();
    for (int i = 0; i < NUM_FWD; i++) set_fwd(i, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] pc);
    fs_to_ds_bus = {1'b0, 32'h0000_0013, pc};
  endtask

  initial begin
    reset = 1'b1;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus = '0;
    es_allowin = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    ex_from_ws = 1'b0;
    fwd_valid = '0;
    fwd_we = '0;
    fwd_dest = '0;
    fwd_data = '0;
    fwd_ready = '0;
    step();
    step();
    check("rst_ds_valid", 65'(ds_valid), 65'd0);
    check("rst_ds_bus", 65'(ds_bus), 65'd0);
    check("rst_stall_cnt", 65'(stall_cnt), 65'd0);
    check("rst_to_es", 65'(ds_to_es_valid), 65'd0);
    check("rst_hazard", 65'(hazard_stall), 65'd0);
    reset = 1'b0;

    // Accept first instruction
    fs_to_ds_valid = 1'b1;
    fetch(32'hBFC0_0000);
    es_allowin = 1'b1;
    step();
    check("t1_ds_valid", 65'(ds_valid), 65'd1);
    check("t1_pc", 65'(ds_bus[31:0]), 65'hBFC0_0000);
    check("t1_to_es", 65'(ds_to_es_valid), 65'd1);
    check("t1_stall_cnt", 65'(stall_cnt), 65'd0);

    // EX back-pressure holds the register
    es_allowin = 1'b0;
    fetch(32'hBFC0_0004);
    #1;
    check("bp_allowin", 65'(ds_allowin), 65'd0);
    step();
    check("bp_hold_pc", 65'(ds_bus[31:0]), 65'hBFC0_0000);
    es_allowin = 1'b1;
    step();
    check("bp_load_pc", 65'(ds_bus[31:0]), 65'hBFC0_0004);
    fs_to_ds_valid = 1'b0;

    // EX forwarding beats WB
    rs_addr = 5'd5;
    rs_used = 1'b1;
    rf_rdata1 = 32'h1111;
    set_fwd(0, 1'b1, 5'd5, 32'h1234, 1'b1);
    set_fwd(2, 1'b1, 5'd5, 32'hDEAD, 1'b1);
    #1;
    check("t2_rs_ex", 65'(rs_value), 65'h1234);
    check("t2_hazard", 65'(hazard_stall), 65'd0);
    set_fwd(0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("t2_rs_wb", 65'(rs_value), 65'hDEAD);
    clr_fwd();
    #1;
    check("t2_rs_rf", 65'(rs_value), 65'h1111);
    rs_used = 1'b0;

    // Load-use: younger not-ready shadows older ready
    rt_addr = 5'd8;
    rt_used = 1'b1;
    rf_rdata2 = 32'h2222;
    set_fwd(0, 1'b1, 5'd8, 32'h0BAD, 1'b0);
    set_fwd(1, 1'b1, 5'd8, 32'hCAFE, 1'b1);
    #1;
    check("t3_hazard", 65'(hazard_stall), 65'd1);
    check("t3_to_es", 65'(ds_to_es_valid), 65'd0);
    check("t3_allowin", 65'(ds_allowin), 65'd0);
    rt_used = 1'b0;
    #1;
    check("t3_unused_rt", 65'(hazard_stall), 65'd0);
    rt_used = 1'b1;
    step();
    check("t3_cnt", 65'(stall_cnt), 65'd1);
    check("t3_hold_valid", 65'(ds_valid), 65'd1);
    check("t3_hold_pc", 65'(ds_bus[31:0]), 65'hBFC0_0004);
    set_fwd(0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("t3_rt_val", 65'(rt_value), 65'hCAFE);
    check("t3_release", 65'(hazard_stall), 65'd0);
    check("t3_issue", 65'(ds_to_es_valid), 65'd1);
    step();
    check("t3_drain", 65'(ds_valid), 65'd0);
    check("t3_cnt_hold", 65'(stall_cnt), 65'd1);
    clr_fwd();
    rt_used = 1'b0;

    // Register 0 never forwards
    fs_to_ds_valid = 1'b1;
    fetch(32'hBFC0_0008);
    step();
    fs_to_ds_valid = 1'b0;
    rs_addr = 5'd0;
    rs_used = 1'b1;
    rf_rdata1 = 32'h0;
    set_fwd(0, 1'b1, 5'd0, 32'hFFFF, 1'b0);
    #1;
    check("t4_rs_zero", 65'(rs_value), 65'h0);
    check("t4_hazard", 65'(hazard_stall), 65'd0);
    clr_fwd();
    rs_used = 1'b0;

    // Flush during stall
    rt_used = 1'b1;
    set_fwd(0, 1'b1, 5'd8, 32'h0BAD, 1'b0);
    #1;
    check("t5_hazard", 65'(hazard_stall), 65'd1);
    step();
    check("t5_cnt", 65'(stall_cnt), 65'd2);
    ex_from_ws = 1'b1;
    fs_to_ds_valid = 1'b1;
    fetch(32'h1234_5678);
    #1;
    check("t5_to_es", 65'(ds_to_es_valid), 65'd0);
    step();
    check("t5_valid", 65'(ds_valid), 65'd0);
    check("t5_pc_hold", 65'(ds_bus[31:0]), 65'hBFC0_0008);
    check("t5_hazard_off", 65'(hazard_stall), 65'd0);
    check("t5_cnt_kept", 65'(stall_cnt), 65'd3);
    ex_from_ws = 1'b0;

    // Saturation of 4-bit counter
    fetch(32'hBFC0_000C);
    step();
    fs_to_ds_valid = 1'b0;
    check("t6_hazard", 65'(hazard_stall), 65'd1);
    check("t6_cnt0", 65'(stall_cnt), 65'd3);
    repeat (10) step();
    check("t6_cnt13", 65'(stall_cnt), 65'd13);
    repeat (10) step();
    check("t6_cnt_sat", 65'(stall_cnt), 65'd15);
    check("t6_pc", 65'(ds_bus[31:0]), 65'hBFC0_000C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
